// File: rtl/uno_pkg.sv
// Shared UNO card encodings and draw-command helpers used by the player-side logic.
package uno_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [3:0] {
    V0    = 4'd0,
    V1    = 4'd1,
    V2    = 4'd2,
    V3    = 4'd3,
    V4    = 4'd4,
    V5    = 4'd5,
    V6    = 4'd6,
    V7    = 4'd7,
    V8    = 4'd8,
    V9    = 4'd9,
    SKIP  = 4'd10,
    REV   = 4'd11,
    DRAW2 = 4'd12,
    WILD  = 4'd13,
    WILD4 = 4'd14
  } value_t;

  typedef struct packed {
    color_t color;
    value_t value;
  } card_t;

  localparam logic [2:0] DRAW_ONE  = 3'b001;
  localparam logic [2:0] DRAW_TWO  = 3'b010;
  localparam logic [2:0] DRAW_FOUR = 3'b100;

  function automatic logic is_draw_cmd(input logic [2:0] cmd);
    return (cmd == DRAW_ONE) || (cmd == DRAW_TWO) || (cmd == DRAW_FOUR);
  endfunction

  // Number of deck strobes expected for an accepted one-hot draw command.
  function automatic logic [2:0] draw_cards(input logic [2:0] cmd);
    logic [2:0] n;
    n = 3'd0;
    case (cmd)
      DRAW_ONE:  n = 3'd1;
      DRAW_TWO:  n = 3'd2;
      DRAW_FOUR: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/player_hand.sv
// Per-player UNO hand: requests cards from the deck, stores them in a flop array,
// removes played cards by shift-down compaction and exposes a cursor-selected card.
module player_hand
  import uno_pkg::*;
#(
  parameter int MAX_CARDS = 32,
  parameter int CARD_W    = 6,
  parameter int IDX_W     = $clog2(MAX_CARDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_draw_num,
  output logic [2:0]        o_draw,
  input  logic              i_drawn,
  input  logic [CARD_W-1:0] i_card,
  input  logic              i_play,
  input  logic [IDX_W-1:0]  i_play_idx,
  output logic              o_play_valid,
  output logic [CARD_W-1:0] o_play_card,
  input  logic              i_sel_next,
  input  logic              i_sel_prev,
  output logic [IDX_W-1:0]  o_sel_idx,
  output logic [CARD_W-1:0] o_sel_card,
  output logic [IDX_W:0]    o_count,
  output logic              o_uno,
  output logic              o_empty,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_REMOVE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(MAX_CARDS);

  state_t                               r_state;
  logic [MAX_CARDS-1:0][CARD_W-1:0]     r_slots;
  logic [IDX_W:0]                       r_count;
  logic [IDX_W-1:0]                     r_sel;
  logic [IDX_W-1:0]                     r_ptr;
  logic [2:0]                           r_rem;

  logic [IDX_W:0]   w_count_m1;
  logic [IDX_W-1:0] w_ptr_inc;
  logic             w_full;
  logic             w_draw_req;
  logic             w_draw_ok;
  logic             w_play_ok;
  logic             w_sel_last;
  logic             w_move_next;
  logic             w_move_prev;
  logic [IDX_W-1:0] w_sel_exit;

  assign w_count_m1  = r_count - CNT_ONE;
  assign w_ptr_inc   = r_ptr + 1'b1;
  assign w_full      = (r_count == CNT_FULL);
  assign w_draw_req  = |i_draw_num;
  assign w_draw_ok   = is_draw_cmd(i_draw_num);
  assign w_play_ok   = ({1'b0, i_play_idx} < r_count);
  assign w_sel_last  = ({1'b0, r_sel} == w_count_m1);
  assign w_move_next = i_sel_next && !i_sel_prev;
  assign w_move_prev = i_sel_prev && !i_sel_next;

  // Cursor fix-up applied on the last REMOVE cycle, against the post-removal count.
  // NOTE: a default assignment first means every path drives w_sel_exit, so no latch is inferred.
  always_comb begin
    w_sel_exit = r_sel;
    if ({1'b0, r_sel} >= w_count_m1) begin
      if (w_count_m1 == '0) w_sel_exit = '0;
      else                  w_sel_exit = IDX_W'(w_count_m1 - CNT_ONE);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the slot array is reset with the rest of the state; it is flops, and an empty hand must read as zeros.
      r_slots      <= '0;
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_sel        <= '0;
      r_ptr        <= '0;
      r_rem        <= '0;
      o_draw       <= '0;
      o_play_valid <= 1'b0;
      o_play_card  <= '0;
      o_overflow   <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_play_valid <= 1'b0;
      o_err        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_draw_req) begin
            if (w_draw_ok) begin
              o_draw  <= i_draw_num;
              r_rem   <= draw_cards(i_draw_num);
              r_state <= ST_DRAW;
              if (i_play) o_err <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end else if (i_play) begin
            if (w_play_ok) begin
              o_play_valid <= 1'b1;
              o_play_card  <= r_slots[i_play_idx];
              r_ptr        <= i_play_idx;
              r_state      <= ST_REMOVE;
            end else begin
              o_err <= 1'b1;
            end
          end else if (r_count == '0) begin
            r_sel <= '0;
          end else if (w_move_next) begin
            r_sel <= w_sel_last ? '0 : r_sel + 1'b1;
          end else if (w_move_prev) begin
            r_sel <= (r_sel == '0) ? w_count_m1[IDX_W-1:0] : r_sel - 1'b1;
          end
        end

        ST_DRAW: begin
          if (i_drawn) begin
            if (w_full) begin
              o_overflow <= 1'b1;
            end else begin
              r_slots[r_count[IDX_W-1:0]] <= i_card;
              r_count                     <= r_count + CNT_ONE;
            end
            r_rem <= r_rem - 3'd1;
            if (r_rem == 3'd1) begin
              o_draw  <= '0;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_REMOVE: begin
          if ({1'b0, r_ptr} < w_count_m1) begin
            r_slots[r_ptr] <= r_slots[w_ptr_inc];
            r_ptr          <= w_ptr_inc;
          end else begin
            r_slots[r_ptr] <= '0;
            r_count        <= w_count_m1;
            r_sel          <= w_sel_exit;
            r_state        <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_sel_idx  = r_sel;
  assign o_sel_card = r_slots[r_sel];
  assign o_count    = r_count;
  assign o_uno      = (r_count == CNT_ONE);
  assign o_empty    = (r_count == '0);
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_player_hand.sv
// Directed bench for player_hand: draw, play/compaction, cursor, overflow, error and reset cases.
`timescale 1ns/1ps
module tb_player_hand;
  import uno_pkg::*;

  localparam int MAX_CARDS = 32;
  localparam int CARD_W    = 6;
  localparam int IDX_W     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        draw_num;
  logic [2:0]        draw;
  logic              drawn;
  logic [CARD_W-1:0] card;
  logic              play;
  logic [IDX_W-1:0]  play_idx;
  logic              play_valid;
  logic [CARD_W-1:0] play_card;
  logic              sel_next;
  logic              sel_prev;
  logic [IDX_W-1:0]  sel_idx;
  logic [CARD_W-1:0] sel_card;
  logic [IDX_W:0]    count;
  logic              uno;
  logic              empty;
  logic              busy;
  logic              overflow;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_hand #(.MAX_CARDS(MAX_CARDS), .CARD_W(CARD_W), .IDX_W(IDX_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_draw_num(draw_num), .o_draw(draw),
    .i_drawn(drawn), .i_card(card),
    .i_play(play), .i_play_idx(play_idx),
    .o_play_valid(play_valid), .o_play_card(play_card),
    .i_sel_next(sel_next), .i_sel_prev(sel_prev),
    .o_sel_idx(sel_idx), .o_sel_card(sel_card),
    .o_count(count), .o_uno(uno), .o_empty(empty),
    .o_busy(busy), .o_overflow(overflow), .o_err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deliver(input logic [CARD_W-1:0] c);
    drawn = 1'b1;
    card  = c;
    tick();
    drawn = 1'b0;
  endtask

  task automatic draw_block(input logic [2:0] cmd, input int n, input int base);
    draw_num = cmd;
    tick();
    draw_num = 3'b000;
    for (int k = 0; k < n; k++) deliver(CARD_W'(base + k));
  endtask

  task automatic step_next();
    sel_next = 1'b1;
    tick();
    sel_next = 1'b0;
  endtask

  task automatic step_prev();
    sel_prev = 1'b1;
    tick();
    sel_prev = 1'b0;
  endtask

  task automatic play_at(input logic [IDX_W-1:0] idx);
    play     = 1'b1;
    play_idx = idx;
    tick();
    play     = 1'b0;
  endtask

  logic [CARD_W-1:0] hand1 [4];

  initial begin
    hand1[0] = 6'h05; hand1[1] = 6'h1A; hand1[2] = 6'h2C; hand1[3] = 6'h3E;
    rst = 1'b1; draw_num = 3'b000; drawn = 1'b0; card = '0;
    play = 1'b0; play_idx = '0; sel_next = 1'b0; sel_prev = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    check("reset_count", 32'(count), 0);
    check("reset_draw", 32'(draw), 0);
    check("reset_empty", 32'(empty), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_sel", 32'(sel_idx), 0);
    check("reset_ovf", 32'(overflow), 0);

    // Empty hand holds cursor at 0.
    step_next();
    check("empty_cursor", 32'(sel_idx), 0);

    // Test 1: draw four.
    draw_num = DRAW_FOUR;
    tick();
    draw_num = 3'b000;
    check("t1_draw_req", 32'(draw), 32'h4);
    check("t1_busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) deliver(hand1[k]);
    check("t1_draw_hold", 32'(draw), 32'h4);
    tick();
    check("t1_gap_count", 32'(count), 3);
    deliver(hand1[3]);
    check("t1_draw_drop", 32'(draw), 0);
    check("t1_idle", 32'(busy), 0);
    check("t1_count", 32'(count), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_slot%0d", k), 32'(sel_card), 32'(hand1[k]));
      step_next();
    end
    check("t1_wrap", 32'(sel_idx), 0);

    // Test 2: play idx 1 of four.
    play_at(5'd1);
    check("t2_valid", 32'(play_valid), 1);
    check("t2_card", 32'(play_card), 32'h1A);
    check("t2_busy0", 32'(busy), 1);
    play = 1'b1; play_idx = 5'd9;
    tick();
    play = 1'b0;
    check("t2_valid_pulse", 32'(play_valid), 0);
    check("t2_busy1", 32'(busy), 1);
    check("t2_busy_no_err", 32'(err), 0);
    tick();
    check("t2_busy2", 32'(busy), 1);
    tick();
    check("t2_done", 32'(busy), 0);
    check("t2_count", 32'(count), 3);
    check("t2_slot0", 32'(sel_card), 32'h05);
    step_next();
    check("t2_slot1", 32'(sel_card), 32'h2C);
    step_next();
    check("t2_slot2", 32'(sel_card), 32'h3E);
    step_next();

    // Test 4: rejected commands with count=3.
    play_at(5'd3);
    check("t4_bad_idx_err", 32'(err), 1);
    check("t4_bad_idx_busy", 32'(busy), 0);
    check("t4_bad_idx_cnt", 32'(count), 3);
    tick();
    check("t4_err_pulse", 32'(err), 0);
    draw_num = 3'b011;
    tick();
    draw_num = 3'b000;
    check("t4_bad_draw_err", 32'(err), 1);
    check("t4_bad_draw_req", 32'(draw), 0);
    check("t4_bad_draw_busy", 32'(busy), 0);
    draw_num = DRAW_ONE; play = 1'b1; play_idx = 5'd0;
    tick();
    draw_num = 3'b000; play = 1'b0;
    check("t4_both_err", 32'(err), 1);
    check("t4_both_draw", 32'(draw), 32'h1);
    check("t4_both_noplay", 32'(play_valid), 0);
    deliver(6'h07);
    check("t4_both_count", 32'(count), 4);

    // Cursor prev wraps 0 -> 3; removing last slot pulls cursor to 2.
    step_prev();
    check("prev_wrap", 32'(sel_idx), 3);
    check("prev_card", 32'(sel_card), 32'h07);
    play_at(5'd3);
    check("last_card", 32'(play_card), 32'h07);
    tick();
    check("last_one_cycle", 32'(busy), 0);
    check("last_sel", 32'(sel_idx), 2);
    check("last_count", 32'(count), 3);

    // Test 5: cursor fix-up and uno/empty.
    play_at(5'd2);
    check("t5_card", 32'(play_card), 32'h3E);
    tick();
    check("t5_sel", 32'(sel_idx), 1);
    check("t5_count", 32'(count), 2);
    step_next();
    check("t5_next_wrap", 32'(sel_idx), 0);
    sel_next = 1'b1; sel_prev = 1'b1;
    tick();
    sel_next = 1'b0; sel_prev = 1'b0;
    check("t5_both_hold", 32'(sel_idx), 0);
    step_next();
    check("t5_next2", 32'(sel_idx), 1);
    play_at(5'd0);
    check("t5_play_a", 32'(play_card), 32'h05);
    tick(); tick();
    check("t5_uno", 32'(uno), 1);
    check("t5_uno_sel", 32'(sel_idx), 0);
    check("t5_uno_card", 32'(sel_card), 32'h2C);
    play_at(5'd0);
    check("t5_play_b", 32'(play_card), 32'h2C);
    tick();
    check("t5_empty", 32'(empty), 1);
    check("t5_not_uno", 32'(uno), 0);
    check("t5_empty_sel", 32'(sel_idx), 0);

    // Test 3: fill to 31 then draw two.
    for (int b = 0; b < 7; b++) draw_block(DRAW_FOUR, 4, b * 4);
    draw_block(DRAW_TWO, 2, 28);
    draw_block(DRAW_ONE, 1, 30);
    check("t3_count31", 32'(count), 31);
    check("t3_no_ovf", 32'(overflow), 0);
    draw_num = DRAW_TWO;
    tick();
    draw_num = 3'b000;
    deliver(6'h11);
    check("t3_count32", 32'(count), 32);
    check("t3_ovf_early", 32'(overflow), 0);
    deliver(6'h22);
    check("t3_count_sat", 32'(count), 32);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_draw_done", 32'(draw), 0);
    step_prev();
    check("t3_sel31", 32'(sel_idx), 31);
    check("t3_slot31", 32'(sel_card), 32'h11);
    step_prev();
    check("t3_slot30", 32'(sel_card), 32'h1E);
    tick(); tick();
    check("t3_ovf_sticky", 32'(overflow), 1);

    // Test 6: async reset mid-draw.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    draw_num = DRAW_FOUR;
    tick();
    draw_num = 3'b000;
    deliver(6'h09);
    check("t6_pre_count", 32'(count), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_draw_async", 32'(draw), 0);
    check("t6_count", 32'(count), 0);
    check("t6_ovf_clr", 32'(overflow), 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle", 32'(busy), 0);
    deliver(6'h0A);
    check("t6_idle_strobe", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
